// File: rtl/timer_pkg.sv
// Shared types and constants for the timer sequencing controller.
package timer_pkg;

  localparam int unsigned CNT_W_DEF = 32'd8;
  localparam int unsigned PRE_W_DEF = 32'd8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } timer_state_e;

  // Number of clk cycles in RUN between expiries for period p, divider n.
  function automatic int unsigned TICKS(input int unsigned p, input int unsigned n);
    return (p + 32'd1) * (n + 32'd1);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Programmable clk divider: raises tick when the count reaches max_i, then
// wraps to zero. Holds its value whenever it is neither cleared nor enabled.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PRE_W = PRE_W_DEF
) (
  input  logic             clk,
  input  logic             clr_b,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [PRE_W-1:0] max_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] cnt_q;
  logic [PRE_W-1:0] cnt_d;

  assign tick_o = (cnt_q == max_i);

  // Next prescaler count: clear wins, then advance/wrap, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {PRE_W{1'b0}};
    end else if (en_i) begin
      if (tick_o) begin
        cnt_d = {PRE_W{1'b0}};
      end else begin
        cnt_d = cnt_q + PRE_W'(1'b1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) begin
      cnt_q <= {PRE_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer sequencing controller: arms, runs, pauses and expires the counter
// cascade. Period, divider and mode are captured in shadow registers on start
// from IDLE/DONE so that software may rewrite them while the timer runs.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned PRE_W = PRE_W_DEF
) (
  input  logic             clk,
  input  logic             clr_b,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic [CNT_W-1:0] period,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             ctr_en,
  output logic             ctr_clr,
  output logic             expire,
  output logic             busy
);

  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic             oneshot_q, oneshot_d;

  logic tick_s;
  logic adv_s;
  logic at_p_s;

  // Prescaler only advances in RUN cycles that are not being paused; ARM
  // restarts it so every run begins on a fresh divide period.
  assign adv_s  = (state_q == RUN) && !stop;
  assign at_p_s = (cnt_i == period_q);

  timer_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk    (clk),
    .clr_b  (clr_b),
    .clr_i  (state_q == ARM),
    .en_i   (adv_s),
    .max_i  (prescale_q),
    .tick_o (tick_s)
  );

  // Output decode. A cascade value above P is not an expiry: it keeps
  // counting and wraps through all-ones back to P.
  assign ctr_en  = adv_s && tick_s && !at_p_s;
  assign expire  = adv_s && tick_s && at_p_s;
  assign ctr_clr = (state_q == ARM) || expire;
  assign busy    = (state_q == ARM) || (state_q == RUN) || (state_q == PAUSE);

  // Next state and shadow capture; stop always wins over start.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    oneshot_d  = oneshot_q;
    case (state_q)
      IDLE, DONE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d    = ARM;
          period_d   = period;
          prescale_d = prescale;
          oneshot_d  = oneshot;
        end else begin
          state_d = state_q;
        end
      end
      ARM: begin
        state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          state_d = PAUSE;
        end else if (expire && oneshot_q) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
        end else begin
          state_d = PAUSE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and shadow registers.
  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) begin
      state_q    <= IDLE;
      period_q   <= {CNT_W{1'b0}};
      prescale_q <= {PRE_W{1'b0}};
      oneshot_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      oneshot_q  <= oneshot_d;
    end
  end

endmodule
